// File: rtl/std_counter_scheduler_if.sv
// std_counter_scheduler_if
// Request/response bundle between the requesters and the shared interval
// counter. The requester side drives valid, terminal counts and abort; the
// scheduler side answers with ready, done pulses and its status.

interface std_counter_scheduler_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]       req_valid;
    logic [CHANNELS-1:0]       req_ready;
    logic [CHANNELS*WIDTH-1:0] req_count;
    logic                      abort;
    logic [CHANNELS-1:0]       done;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic [WIDTH-1:0]          value;

    // Requester side
    modport master (
        output req_valid,
        output req_count,
        output abort,
        input  req_ready,
        input  done,
        input  busy,
        input  grant_id,
        input  value
    );

    // Scheduler side
    modport slave (
        input  req_valid,
        input  req_count,
        input  abort,
        output req_ready,
        output done,
        output busy,
        output grant_id,
        output value
    );
endinterface

// File: rtl/std_counter_scheduler.sv
// std_counter_scheduler
// One interval counter shared round-robin between CHANNELS requesters.
// A requester hands over a terminal count N; the counter runs 0..N (N+1
// cycles), then the owner receives a one-cycle done pulse.
// Optional build macro: STD_COUNTER_SCHEDULER_STATS_EN adds completion and
// abort counters (stat_completed / stat_aborted).

module std_counter_scheduler #(
    parameter logic [0:0] CLOCK_INFO = 1'b0,
    parameter int         CHANNELS   = 4,
    parameter int         WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    std_counter_scheduler_if.slave       bus
`ifdef STD_COUNTER_SCHEDULER_STATS_EN
    ,
    output logic [31:0]                  stat_completed,
    output logic [31:0]                  stat_aborted
`endif
);

    localparam int ID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(CHANNELS - 1);

    // Registered state
    logic [1:0]       state_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] term_q;
    logic [ID_W-1:0]  grant_q;
    logic [ID_W-1:0]  rr_q;

    // Next-state values
    logic [1:0]       state_d;
    logic [WIDTH-1:0] value_d;
    logic [WIDTH-1:0] term_d;
    logic [ID_W-1:0]  grant_d;
    logic [ID_W-1:0]  rr_d;

    // Arbiter results
    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    logic [WIDTH-1:0] sel_count;
    logic             handshake;
    logic             run_abort;
    logic             run_match;

    logic [CHANNELS-1:0] ready_vec;
    logic [CHANNELS-1:0] done_vec;

    // Round-robin search: first valid channel at or above the rr pointer, with wrap
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % CHANNELS;
            if (!sel_found && bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    // Terminal count of the selected channel, only used on the handshake cycle
    always_comb begin
        sel_count = bus.req_count[int'(sel_id)*WIDTH +: WIDTH];
    end

    assign handshake = (state_q == IDLE) && sel_found && !rst;
    assign run_abort = (state_q == RUN) && bus.abort;
    assign run_match = (state_q == RUN) && (value_q == term_q);

    // Ready is offered only in IDLE to the selected channel and never during reset
    always_comb begin
        ready_vec = '0;
        if (handshake) begin
            ready_vec[sel_id] = 1'b1;
        end
    end

    // Completion pulse decoded straight from the DONE state for the owner
    always_comb begin
        done_vec = '0;
        if (state_q == DONE) begin
            done_vec[grant_q] = 1'b1;
        end
    end

    // Next-state logic; abort takes priority over the terminal match in RUN
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        term_d  = term_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                value_d = '0;
                if (handshake) begin
                    grant_d = sel_id;
                    term_d  = sel_count;
                    rr_d    = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_abort) begin
                    state_d = IDLE;
                    value_d = '0;
                end else if (run_match) begin
                    state_d = DONE;
                    value_d = '0;
                end else begin
                    value_d = value_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                value_d = '0;
            end
            default: begin
                state_d = IDLE;
                value_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            term_q  <= '0;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            term_q  <= term_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

`ifdef STD_COUNTER_SCHEDULER_STATS_EN
    // Event counters: one per done pulse and one per honoured abort, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_completed <= '0;
            stat_aborted   <= '0;
        end else begin
            if (state_q == DONE) begin
                stat_completed <= stat_completed + 32'd1;
            end
            if (run_abort) begin
                stat_aborted <= stat_aborted + 32'd1;
            end
        end
    end
`endif

    assign bus.req_ready = ready_vec;
    assign bus.done      = done_vec;
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.grant_id  = grant_q;
    assign bus.value     = value_q;

endmodule

// File: tb/tb_std_counter_scheduler.sv
// tb_std_counter_scheduler
// Directed bench for std_counter_scheduler with CHANNELS=4, WIDTH=4.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit after that, well away from the next edge.

module tb_std_counter_scheduler;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 4;

    logic clk;
    logic rst;

    int checkCount;
    int errorCount;

    std_counter_scheduler_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

`ifdef STD_COUNTER_SCHEDULER_STATS_EN
    logic [31:0] stat_completed;
    logic [31:0] stat_aborted;
`endif

    std_counter_scheduler #(
        .CLOCK_INFO (1'b0),
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef STD_COUNTER_SCHEDULER_STATS_EN
        ,
        .stat_completed (stat_completed),
        .stat_aborted   (stat_aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive requester inputs and let the combinational ready settle
    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] counts, input logic ab);
        bus.req_valid = valid;
        bus.req_count = counts;
        bus.abort     = ab;
        #1;
    endtask

    // Advance one clock and move just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous reset for two cycles with all requests idle
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [3:0] oneHot(input int ch);
        logic [3:0] v;
        v = 4'b0001 << ch;
        return v;
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        applyStimulus(4'b1111, 16'h0000, 1'b0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_value", 32'(bus.value), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        checkOutput("rst_grant", 32'(bus.grant_id), 32'h0);
        doReset();

        $display("[TB] single job ch1 count 3");
        applyStimulus(4'b0010, 16'h0030, 1'b0);
        checkOutput("s_ready", 32'(bus.req_ready), 32'h2);
        checkOutput("s_busy0", 32'(bus.busy), 32'h0);
        tick();
        applyStimulus(4'b0000, 16'h0030, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("s_value", 32'(bus.value), 32'(i));
            checkOutput("s_busy", 32'(bus.busy), 32'h1);
            checkOutput("s_nodone", 32'(bus.done), 32'h0);
            checkOutput("s_grant", 32'(bus.grant_id), 32'h1);
            tick();
        end
        checkOutput("s_done", 32'(bus.done), 32'h2);
        checkOutput("s_busy5", 32'(bus.busy), 32'h1);
        checkOutput("s_value5", 32'(bus.value), 32'h0);
        tick();
        checkOutput("s_done6", 32'(bus.done), 32'h0);
        checkOutput("s_busy6", 32'(bus.busy), 32'h0);
        checkOutput("s_grant6", 32'(bus.grant_id), 32'h1);
`ifdef STD_COUNTER_SCHEDULER_STATS_EN
        checkOutput("s_stat_c", stat_completed, 32'd1);
`endif

        $display("[TB] contention ch0 and ch2");
        doReset();
        applyStimulus(4'b0101, 16'h0201, 1'b0);
        checkOutput("c_ready0", 32'(bus.req_ready), 32'h1);
        tick();
        checkOutput("c_grant0", 32'(bus.grant_id), 32'h0);
        checkOutput("c_value0", 32'(bus.value), 32'h0);
        checkOutput("c_ready_run", 32'(bus.req_ready), 32'h0);
        tick();
        checkOutput("c_value1", 32'(bus.value), 32'h1);
        applyStimulus(4'b0100, 16'h0201, 1'b0);
        tick();
        checkOutput("c_done0", 32'(bus.done), 32'h1);
        checkOutput("c_ready_done", 32'(bus.req_ready), 32'h0);
        tick();
        checkOutput("c_ready2", 32'(bus.req_ready), 32'h4);
        checkOutput("c_idle_busy", 32'(bus.busy), 32'h0);
        tick();
        applyStimulus(4'b0000, 16'h0201, 1'b0);
        checkOutput("c_grant2", 32'(bus.grant_id), 32'h2);
        tick();
        tick();
        checkOutput("c_value2", 32'(bus.value), 32'h2);
        tick();
        checkOutput("c_done2", 32'(bus.done), 32'h4);

        $display("[TB] fairness all channels count 0");
        doReset();
        applyStimulus(4'b1111, 16'h0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("f_ready", 32'(bus.req_ready), 32'(oneHot(k % 4)));
            tick();
            checkOutput("f_grant", 32'(bus.grant_id), 32'(k % 4));
            checkOutput("f_run_done", 32'(bus.done), 32'h0);
            tick();
            checkOutput("f_done", 32'(bus.done), 32'(oneHot(k % 4)));
            tick();
        end
        applyStimulus(4'b0000, 16'h0000, 1'b0);

        $display("[TB] abort ch3 at value 4");
        doReset();
        applyStimulus(4'b1000, 16'hA000, 1'b0);
        checkOutput("a_ready", 32'(bus.req_ready), 32'h8);
        tick();
        applyStimulus(4'b0000, 16'hA000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("a_value", 32'(bus.value), 32'(i));
            if (i < 4) tick();
        end
        applyStimulus(4'b0000, 16'hA000, 1'b1);
        tick();
        applyStimulus(4'b1001, 16'hA000, 1'b0);
        checkOutput("a_busy", 32'(bus.busy), 32'h0);
        checkOutput("a_value0", 32'(bus.value), 32'h0);
        checkOutput("a_nodone", 32'(bus.done), 32'h0);
        checkOutput("a_next_ready", 32'(bus.req_ready), 32'h1);
        checkOutput("a_grant_hold", 32'(bus.grant_id), 32'h3);
`ifdef STD_COUNTER_SCHEDULER_STATS_EN
        checkOutput("a_stat_a", stat_aborted, 32'd1);
        checkOutput("a_stat_c", stat_completed, 32'd0);
`endif
        tick();
        applyStimulus(4'b0000, 16'hA000, 1'b0);
        checkOutput("a_grant0", 32'(bus.grant_id), 32'h0);
        tick();
        checkOutput("a_done0", 32'(bus.done), 32'h1);
        tick();

        $display("[TB] abort coincident with terminal match");
        applyStimulus(4'b0010, 16'h0020, 1'b0);
        tick();
        applyStimulus(4'b0000, 16'h0020, 1'b0);
        tick();
        tick();
        checkOutput("m_value2", 32'(bus.value), 32'h2);
        applyStimulus(4'b0000, 16'h0020, 1'b1);
        tick();
        checkOutput("m_nodone", 32'(bus.done), 32'h0);
        checkOutput("m_busy", 32'(bus.busy), 32'h0);
        applyStimulus(4'b0100, 16'h0020, 1'b1);
        checkOutput("m_idle_abort_ready", 32'(bus.req_ready), 32'h4);
        tick();
        applyStimulus(4'b0000, 16'h0020, 1'b0);
        checkOutput("m_grant2", 32'(bus.grant_id), 32'h2);
        checkOutput("m_busy2", 32'(bus.busy), 32'h1);
        tick();
        checkOutput("m_done2", 32'(bus.done), 32'h4);
        tick();

        $display("[TB] boundary count 15");
        doReset();
        applyStimulus(4'b0010, 16'h00F0, 1'b0);
        tick();
        applyStimulus(4'b0000, 16'h00F0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("b_value", 32'(bus.value), 32'(i));
            checkOutput("b_nodone", 32'(bus.done), 32'h0);
            tick();
        end
        checkOutput("b_done", 32'(bus.done), 32'h2);
        checkOutput("b_value_wrap", 32'(bus.value), 32'h0);
        tick();
        checkOutput("b_done_once", 32'(bus.done), 32'h0);
        checkOutput("b_idle", 32'(bus.busy), 32'h0);

        $display("[TB] reset mid-run");
        doReset();
        applyStimulus(4'b0100, 16'h0900, 1'b0);
        tick();
        applyStimulus(4'b0000, 16'h0900, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("r_value", 32'(bus.value), 32'(i));
            if (i < 5) tick();
        end
        rst = 1'b1;
        applyStimulus(4'b1111, 16'h0900, 1'b0);
        tick();
        checkOutput("r_value0", 32'(bus.value), 32'h0);
        checkOutput("r_busy", 32'(bus.busy), 32'h0);
        checkOutput("r_done", 32'(bus.done), 32'h0);
        checkOutput("r_ready_forced", 32'(bus.req_ready), 32'h0);
        checkOutput("r_grant", 32'(bus.grant_id), 32'h0);
`ifdef STD_COUNTER_SCHEDULER_STATS_EN
        checkOutput("r_stat_c", stat_completed, 32'd0);
        checkOutput("r_stat_a", stat_aborted, 32'd0);
`endif
        tick();
        rst = 1'b0;
        #1;
        checkOutput("r_ready_after", 32'(bus.req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
